// File: rtl/rx_crc_check.sv
// Receive FCS/length checker: CRC-32 over the kept payload bytes, flags bad frames in tuser on tlast.
// Define RX_CRC_CHECK_STATS_EN to add the frame / CRC-error / length-error counters.
module rx_crc_check #(
    parameter int DATA_BYTES      = 8,
    parameter int DATA_BITS       = DATA_BYTES*8,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_BITS-1:0]  saxis_tdata,
    input  logic                  saxis_tvalid,
    output logic                  saxis_tready,
    input  logic [DATA_BYTES-1:0] saxis_tkeep,
    input  logic                  saxis_tlast,
    input  logic                  saxis_tuser,
    input  logic [31:0]           crc_in,
    output logic [DATA_BITS-1:0]  maxis_tdata,
    output logic                  maxis_tvalid,
    input  logic                  maxis_tready,
    output logic [DATA_BYTES-1:0] maxis_tkeep,
    output logic                  maxis_tlast,
    output logic                  maxis_tuser
`ifdef RX_CRC_CHECK_STATS_EN
    ,
    output logic [31:0]           frame_count,
    output logic [31:0]           crc_error_count,
    output logic [31:0]           length_error_count
`endif
);

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_BYTES);

    logic [31:0]           crc_q, crc_d, crc_fold;
    logic [15:0]           cnt_q, cnt_d, keep_cnt, len_total;
    logic [16:0]           cnt_sum;
    logic                  accept, fcs_ok, len_bad;

    logic [DATA_BITS-1:0]  tdata_q;
    logic [DATA_BYTES-1:0] tkeep_q;
    logic                  tvalid_q, tlast_q, tuser_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign saxis_tready = !tvalid_q || maxis_tready;
    assign accept       = saxis_tvalid && saxis_tready;

    // Bytes are folded in wire order; unkept bytes are skipped entirely.
    always_comb begin
        crc_fold = crc_q;
        keep_cnt = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (saxis_tkeep[i]) begin
                crc_fold = crc_byte(crc_fold, saxis_tdata[8*i +: 8]);
                keep_cnt = keep_cnt + 16'd1;
            end
        end
    end

    assign cnt_sum   = {1'b0, cnt_q} + {1'b0, keep_cnt};
    assign len_total = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign fcs_ok    = (~crc_fold == crc_in);
    assign len_bad   = (len_total < MIN_LEN) || (len_total > MAX_LEN);

    always_comb begin
        crc_d = crc_q;
        cnt_d = cnt_q;
        if (accept) begin
            if (saxis_tlast) begin
                crc_d = CRC_INIT;
                cnt_d = '0;
            end else begin
                crc_d = crc_fold;
                cnt_d = len_total;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q    <= CRC_INIT;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            crc_q <= crc_d;
            cnt_q <= cnt_d;
            if (accept) begin
                tvalid_q <= 1'b1;
                tdata_q  <= saxis_tdata;
                tkeep_q  <= saxis_tkeep;
                tlast_q  <= saxis_tlast;
                tuser_q  <= saxis_tuser | (saxis_tlast & (!fcs_ok | len_bad));
            end else if (maxis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign maxis_tvalid = tvalid_q;
    assign maxis_tdata  = tdata_q;
    assign maxis_tkeep  = tkeep_q;
    assign maxis_tlast  = tlast_q;
    assign maxis_tuser  = tuser_q;

`ifdef RX_CRC_CHECK_STATS_EN
    logic [31:0] frame_cnt_q, crc_err_cnt_q, len_err_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            crc_err_cnt_q <= '0;
            len_err_cnt_q <= '0;
        end else if (accept && saxis_tlast) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
            if (!fcs_ok) begin
                crc_err_cnt_q <= crc_err_cnt_q + 32'd1;
            end
            if (len_bad) begin
                len_err_cnt_q <= len_err_cnt_q + 32'd1;
            end
        end
    end

    assign frame_count        = frame_cnt_q;
    assign crc_error_count    = crc_err_cnt_q;
    assign length_error_count = len_err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_crc_check.sv
// Scoreboard bench for rx_crc_check: two instances (MIN_FRAME_BYTES=1 and default) share one stimulus stream.
module tb_rx_crc_check;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_tdata  = '0;
    logic [7:0]  s_tkeep  = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        s_tuser  = 1'b0;
    logic [31:0] s_crc    = '0;
    logic        m_tready;

    logic        a_tready, a_tvalid, a_tlast, a_tuser;
    logic [63:0] a_tdata;
    logic [7:0]  a_tkeep;
    logic        b_tready, b_tvalid, b_tlast, b_tuser;
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;
`ifdef RX_CRC_CHECK_STATS_EN
    logic [31:0] a_fc, a_ce, a_le, b_fc, b_ce, b_le;
`endif

    rx_crc_check #(.MIN_FRAME_BYTES(1)) dut_a (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid), .saxis_tready(a_tready),
        .saxis_tkeep(s_tkeep), .saxis_tlast(s_tlast), .saxis_tuser(s_tuser), .crc_in(s_crc),
        .maxis_tdata(a_tdata), .maxis_tvalid(a_tvalid), .maxis_tready(m_tready),
        .maxis_tkeep(a_tkeep), .maxis_tlast(a_tlast), .maxis_tuser(a_tuser)
`ifdef RX_CRC_CHECK_STATS_EN
        , .frame_count(a_fc), .crc_error_count(a_ce), .length_error_count(a_le)
`endif
    );

    rx_crc_check dut_b (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid), .saxis_tready(b_tready),
        .saxis_tkeep(s_tkeep), .saxis_tlast(s_tlast), .saxis_tuser(s_tuser), .crc_in(s_crc),
        .maxis_tdata(b_tdata), .maxis_tvalid(b_tvalid), .maxis_tready(m_tready),
        .maxis_tkeep(b_tkeep), .maxis_tlast(b_tlast), .maxis_tuser(b_tuser)
`ifdef RX_CRC_CHECK_STATS_EN
        , .frame_count(b_fc), .crc_error_count(b_ce), .length_error_count(b_le)
`endif
    );

    initial forever #5 clock = ~clock;

    beat_t      qa[$];
    beat_t      qb[$];
    int         checks = 0;
    int         errors = 0;
    bit         tog_en = 1'b0;
    bit         gap_en = 1'b0;
    logic [7:0] pay [0:2047];
    int         exp_frames = 0, exp_crc = 0, exp_len_a = 0, exp_len_b = 0;
    bit         stall_q [2];
    beat_t      prev [2];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Output-side ready: constant high, or toggling every cycle during the backpressure phase.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            m_tready = tog_en ? ~m_tready : 1'b1;
        end
    end

    task automatic mon(input int w, input beat_t cur, input logic v, input logic rdy);
        beat_t e;
        chk($sformatf("tready_rule dut=%0d", w), 80'(rdy), 80'(!v || m_tready));
        if (stall_q[w]) begin
            chk($sformatf("stall_valid dut=%0d", w), 80'(v), 80'(1));
            chk($sformatf("stall_hold dut=%0d", w), 80'(cur), 80'(prev[w]));
        end
        if (v && m_tready) begin
            if ((w == 0 ? qa.size() : qb.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat dut=%0d actual=%h required=none", w, cur);
            end else begin
                if (w == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                chk($sformatf("beat dut=%0d", w), 80'(cur), 80'(e));
            end
        end
        stall_q[w] = v && !m_tready;
        prev[w]    = cur;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_q[0] = 1'b0;
                stall_q[1] = 1'b0;
            end else begin
                mon(0, {a_tdata, a_tkeep, a_tlast, a_tuser}, a_tvalid, a_tready);
                mon(1, {b_tdata, b_tkeep, b_tlast, b_tuser}, b_tvalid, b_tready);
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic u, input logic [31:0] c, input logic ua, input logic ub);
        int t;
        int g;
        t = 0;
        if (gap_en) begin
            g = $urandom_range(0, 2);
            s_tvalid = 1'b0;
            repeat (g) begin
                @(posedge clock);
                #1;
            end
        end
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_crc = c; s_tvalid = 1'b1;
        forever begin
            @(negedge clock);
            if (a_tready) begin
                qa.push_back({d, k, l, ua});
                qb.push_back({d, k, l, ub});
                @(posedge clock);
                #1;
                break;
            end
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                @(posedge clock);
                #1;
                break;
            end
            @(posedge clock);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic fill(input int len, input int seed);
        for (int i = 0; i < len; i++) pay[i] = 8'(i*7 + seed);
    endtask

    function automatic logic [31:0] crc_of(input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, pay[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected last-beat flags (crc_bad, len_a, len_b) are given by hand per frame.
    task automatic send_frame(input int len, input logic [31:0] c, input logic crc_bad,
                              input logic len_a, input logic len_b, input int phy_beat,
                              input bit zero_last);
        int nbt, idx;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l, u;
        nbt = (len + 7) / 8 + (zero_last ? 1 : 0);
        idx = 0;
        for (int b = 0; b < nbt; b++) begin
            d = '0;
            k = '0;
            l = (b == nbt - 1);
            u = (b == phy_beat);
            for (int j = 0; j < 8; j++) begin
                if (idx < len) begin
                    d[8*j +: 8] = pay[idx];
                    k[j] = 1'b1;
                    idx++;
                end
            end
            send_beat(d, k, l, u, l ? c : 32'h0,
                      u | (l & (crc_bad | len_a)), u | (l & (crc_bad | len_b)));
        end
        exp_frames++;
        exp_crc   += int'(crc_bad);
        exp_len_a += int'(len_a);
        exp_len_b += int'(len_b);
    endtask

    task automatic check_stats();
`ifdef RX_CRC_CHECK_STATS_EN
        chk("frame_count_a", 80'(a_fc), 80'(exp_frames));
        chk("crc_error_count_a", 80'(a_ce), 80'(exp_crc));
        chk("length_error_count_a", 80'(a_le), 80'(exp_len_a));
        chk("frame_count_b", 80'(b_fc), 80'(exp_frames));
        chk("crc_error_count_b", 80'(b_ce), 80'(exp_crc));
        chk("length_error_count_b", 80'(b_le), 80'(exp_len_b));
`endif
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((qa.size() != 0 || qb.size() != 0) && w < 200) begin
            @(posedge clock);
            w++;
        end
        #1;
        chk("drain", 80'(qa.size() + qb.size()), 80'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out_a", 80'({a_tvalid, a_tdata, a_tkeep, a_tlast, a_tuser}), 80'(0));
        chk("reset_out_b", 80'({b_tvalid, b_tdata, b_tkeep, b_tlast, b_tuser}), 80'(0));
        check_stats();
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
        send_frame(9, 32'hCBF4_3926, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        check_stats();
        send_frame(9, 32'hCBF4_3927, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        check_stats();

        fill(59, 3);    send_frame(59,   crc_of(59),   1'b0, 1'b0, 1'b1, -1, 1'b0);
        fill(60, 5);    send_frame(60,   crc_of(60),   1'b0, 1'b0, 1'b0, -1, 1'b0);
        fill(1515, 9);  send_frame(1515, crc_of(1515), 1'b0, 1'b1, 1'b1, -1, 1'b0);
        fill(1514, 11); send_frame(1514, crc_of(1514), 1'b0, 1'b0, 1'b0, -1, 1'b0);
        fill(64, 13);   send_frame(64,   crc_of(64),   1'b0, 1'b0, 1'b0,  2, 1'b0);
        fill(64, 17);   send_frame(64,   crc_of(64),   1'b0, 1'b0, 1'b0, -1, 1'b1);
        drain();
        check_stats();

        tog_en = 1'b1;
        gap_en = 1'b1;
        fill(64, 19);  send_frame(64,  crc_of(64),  1'b0, 1'b0, 1'b0, -1, 1'b0);
        fill(100, 23); send_frame(100, crc_of(100), 1'b0, 1'b0, 1'b0, -1, 1'b0);
        fill(61, 29);  send_frame(61,  crc_of(61),  1'b0, 1'b0, 1'b0, -1, 1'b0);
        tog_en = 1'b0;
        gap_en = 1'b0;
        drain();
        check_stats();

        // Reset two beats into a frame; the partial frame must leave no trace.
        fill(60, 31);
        send_beat({pay[7], pay[6], pay[5], pay[4], pay[3], pay[2], pay[1], pay[0]},
                  8'hFF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        send_beat({pay[15], pay[14], pay[13], pay[12], pay[11], pay[10], pay[9], pay[8]},
                  8'hFF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_a", 80'({a_tvalid, a_tdata, a_tkeep, a_tlast, a_tuser}), 80'(0));
        chk("async_reset_b", 80'({b_tvalid, b_tdata, b_tkeep, b_tlast, b_tuser}), 80'(0));
        qa.delete();
        qb.delete();
        exp_frames = 0; exp_crc = 0; exp_len_a = 0; exp_len_b = 0;
        check_stats();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        fill(60, 37); send_frame(60, crc_of(60), 1'b0, 1'b0, 1'b0, -1, 1'b0);
        drain();
        check_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
